// File: rtl/seg_display_ctrl.sv
// Multiplexed-free 7-segment controller: shadow register, leading-zero
// suppression, per-digit blank/blink masks and a free-running blink timer.
module seg_display_ctrl #(
  parameter int DIGITS    = 8,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_en,
  input  logic                  blink_sync,
  output logic [7*DIGITS-1:0]   segs,
  output logic                  blink_phase
);

  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  logic [4*DIGITS-1:0] shadow_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic [7*DIGITS-1:0] segs_q, segs_d;
  logic [DIGITS-1:0]   supp;
  logic                upper_zero;

  // Active-low encoding, bit 6..0 = g..a.
  function automatic logic [6:0] encode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // A digit is suppressed only if it and every digit above it are zero.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    upper_zero = 1'b1;
    supp       = '0;
    // NOTE: blocking '=' here is deliberate; upper_zero must ripple down within one evaluation.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (shadow_q[4*i +: 4] == 4'h0);
      supp[i]    = lz_en & upper_zero & (i != 0);
    end
  end

  always_comb begin
    segs_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (blank_mask[i])                     segs_d[7*i +: 7] = 7'h7F;
      else if (blink_mask[i] && !phase_q)    segs_d[7*i +: 7] = 7'h7F;
      else if (supp[i])                      segs_d[7*i +: 7] = 7'h7F;
      else                                   segs_d[7*i +: 7] = encode(shadow_q[4*i +: 4]);
    end
  end

  // Sync restarts the timer lit and wins over a coincident wrap.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (blink_sync) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // NOTE: the shadow register is plain flops, so it is reset with the rest; an in-flight load is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
      segs_q   <= '1;
    end else begin
      // NOTE: non-blocking '<=' for all state so every flop samples pre-edge values.
      if (load) shadow_q <= value;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      segs_q  <= segs_d;
    end
  end

  assign segs        = segs_q;
  assign blink_phase = phase_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl with DIGITS=4, BLINK_DIV=4.
module tb_seg_display_ctrl;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] DK = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic        lz_en;
  logic        blink_sync;
  logic [27:0] segs;
  logic        blink_phase;

  int vectors    = 0;
  int miscompares = 0;

  seg_display_ctrl #(.DIGITS(4), .BLINK_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .lz_en      (lz_en),
    .blink_sync (blink_sync),
    .segs       (segs),
    .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Capture v at the next edge; segs reflect it one edge later.
  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic test_reset();
    logic [27:0] exp;
    rst = 1'b1; load = 1'b0; value = '0; blank_mask = '0; blink_mask = '0;
    lz_en = 1'b0; blink_sync = 1'b0;
    tick(); tick();
    vectors++;
    if (segs !== 28'hFFFFFFF) begin
      miscompares++;
      $display("FAIL reset_segs got=%h want=%h", segs, 28'hFFFFFFF);
    end
    vectors++;
    if (blink_phase !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_phase got=%b want=1", blink_phase);
    end
    rst = 1'b0;
    tick();
    exp = {S0, S0, S0, S0};
    vectors++;
    if (segs !== exp) begin
      miscompares++;
      $display("FAIL reset_release got=%h want=%h", segs, exp);
    end
  endtask

  task automatic test_load_latency();
    logic [27:0] exp;
    do_load(16'h1A2F);
    exp = {S0, S0, S0, S0};
    vectors++;
    if (segs !== exp) begin
      miscompares++;
      $display("FAIL load_early got=%h want=%h", segs, exp);
    end
    tick();
    exp = {S1, SA, S2, SF};
    vectors++;
    if (segs !== exp) begin
      miscompares++;
      $display("FAIL load_latency got=%h want=%h", segs, exp);
    end
    value = 16'hFFFF;
    tick(); tick();
    vectors++;
    if (segs !== exp) begin
      miscompares++;
      $display("FAIL load_hold got=%h want=%h", segs, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [27:0] exp;
    value = 16'h1111; load = 1'b1;
    tick();
    value = 16'h2222;
    tick();
    load = 1'b0;
    exp = {S1, S1, S1, S1};
    vectors++;
    if (segs !== exp) begin
      miscompares++;
      $display("FAIL b2b_first got=%h want=%h", segs, exp);
    end
    tick();
    exp = {S2, S2, S2, S2};
    vectors++;
    if (segs !== exp) begin
      miscompares++;
      $display("FAIL b2b_second got=%h want=%h", segs, exp);
    end
  endtask

  task automatic test_leading_zeros();
    logic [15:0] vin  [4];
    logic        lzin [4];
    logic [27:0] want [4];
    vin[0] = 16'h0040; lzin[0] = 1'b1; want[0] = {DK, DK, S4, S0};
    vin[1] = 16'h0000; lzin[1] = 1'b1; want[1] = {DK, DK, DK, S0};
    vin[2] = 16'h0100; lzin[2] = 1'b1; want[2] = {DK, S1, S0, S0};
    vin[3] = 16'h0000; lzin[3] = 1'b0; want[3] = {S0, S0, S0, S0};
    for (int k = 0; k < 4; k++) begin
      lz_en = lzin[k];
      do_load(vin[k]);
      tick();
      vectors++;
      if (segs !== want[k]) begin
        miscompares++;
        $display("FAIL lz_%0d got=%h want=%h", k, segs, want[k]);
      end
    end
    lz_en = 1'b0;
  endtask

  task automatic test_blink();
    logic        exp_ph;
    logic [27:0] exp;
    do_load(16'h1234);
    blink_mask = 4'b0001;
    blink_sync = 1'b1;
    tick();
    blink_sync = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_ph = ((k / 4) % 2) == 0;
      exp    = (((k - 1) / 4) % 2 == 0) ? {S1, S2, S3, S4} : {S1, S2, S3, DK};
      vectors++;
      if (blink_phase !== exp_ph) begin
        miscompares++;
        $display("FAIL blink_phase_%0d got=%b want=%b", k, blink_phase, exp_ph);
      end
      vectors++;
      if (segs !== exp) begin
        miscompares++;
        $display("FAIL blink_segs_%0d got=%h want=%h", k, segs, exp);
      end
    end
  endtask

  task automatic test_priority_sync();
    logic exp_ph;
    blank_mask = 4'b0001;
    blink_mask = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      tick();
      vectors++;
      if (segs !== {S1, S2, S3, DK}) begin
        miscompares++;
        $display("FAIL prio_%0d got=%h want=%h", k, segs, {S1, S2, S3, DK});
      end
    end
    blank_mask = '0;
    blink_sync = 1'b1;
    tick();
    blink_sync = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    vectors++;
    if (blink_phase !== 1'b0) begin
      miscompares++;
      $display("FAIL sync_pre got=%b want=0", blink_phase);
    end
    blink_sync = 1'b1;
    tick();
    blink_sync = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      exp_ph = (k < 4);
      vectors++;
      if (blink_phase !== exp_ph) begin
        miscompares++;
        $display("FAIL sync_after_%0d got=%b want=%b", k, blink_phase, exp_ph);
      end
      if (k < 4) tick();
    end
  endtask

  task automatic test_async_reset();
    blink_mask = '0;
    blink_sync = 1'b1;
    tick();
    blink_sync = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    vectors++;
    if (blink_phase !== 1'b0) begin
      miscompares++;
      $display("FAIL async_pre got=%b want=0", blink_phase);
    end
    value = 16'hFFFF;
    load  = 1'b1;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (segs !== 28'hFFFFFFF) begin
      miscompares++;
      $display("FAIL async_segs got=%h want=%h", segs, 28'hFFFFFFF);
    end
    vectors++;
    if (blink_phase !== 1'b1) begin
      miscompares++;
      $display("FAIL async_phase got=%b want=1", blink_phase);
    end
    #1 rst = 1'b0;
    load = 1'b0;
    tick();
    vectors++;
    if (segs !== {S0, S0, S0, S0}) begin
      miscompares++;
      $display("FAIL async_discard got=%h want=%h", segs, {S0, S0, S0, S0});
    end
  endtask

  initial begin
    test_reset();
    test_load_latency();
    test_back_to_back();
    test_leading_zeros();
    test_blink();
    test_priority_sync();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
